// File: rtl/word_serializer.sv
// word_serializer: turns W-bit words into one bit per clock.
// A one-word holding register lets words stream with no gap bit.
module word_serializer #(
  parameter int unsigned W         = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         x,
  output logic         x_valid,
  output logic         x_last,
  output logic         busy
);

  localparam int unsigned BW = $clog2(W);
  localparam logic [BW-1:0] BC_LAST = BW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  sh, sh_n;
  logic [W-1:0]  hold, hold_n;
  logic [BW-1:0] bc, bc_n;
  logic          hold_full, hold_full_n;

  logic          last;
  logic          free;
  logic          accept;
  logic          head;
  logic [W-1:0]  sh_shifted;

  assign last      = (bc == BC_LAST);
  assign free      = (state == IDLE) || last;
  assign din_ready = !hold_full;
  assign accept    = din_valid && din_ready;
  assign busy      = (state == SHIFT) || hold_full;

  assign head       = MSB_FIRST ? sh[W-1] : sh[0];
  assign sh_shifted = MSB_FIRST ? {sh[W-2:0], IDLE_BIT}
                                : {IDLE_BIT, sh[W-1:1]};

  // Outputs come straight from registered state through a mux.
  always_comb begin
    x       = IDLE_BIT;
    x_valid = 1'b0;
    x_last  = 1'b0;
    if (state == SHIFT) begin
      x       = head;
      x_valid = 1'b1;
      x_last  = last;
    end
  end

  // Next-state: reload from hold, else bypass din, else idle or shift.
  always_comb begin
    state_n     = state;
    sh_n        = sh;
    bc_n        = bc;
    hold_n      = hold;
    hold_full_n = hold_full;
    if (free && hold_full) begin
      sh_n        = hold;
      bc_n        = '0;
      state_n     = SHIFT;
      hold_full_n = 1'b0;
    end else if (free && accept) begin
      sh_n    = din;
      bc_n    = '0;
      state_n = SHIFT;
    end else if (free) begin
      state_n = IDLE;
      bc_n    = '0;
    end else begin
      sh_n = sh_shifted;
      bc_n = bc + 1'b1;
      if (accept) begin
        hold_n      = din;
        hold_full_n = 1'b1;
      end
    end
  end

  // State register; reset drops both the shifter and the hold word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      bc        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      bc        <= bc_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
    end
  end

endmodule
